// File: rtl/game_mode_fsm.sv
// Keyboard-driven mode controller: menu, play, pause and game-over screens
// for NUM_GAMES games, reacting only to key press edges across NUM_KEYS slots.
module game_mode_fsm #(
  parameter int          NUM_GAMES   = 2,
  parameter int          NUM_KEYS    = 2,
  parameter logic [7:0]  KEY_BASE    = 8'h1E,
  parameter logic [7:0]  KEY_EXIT    = 8'h29,
  parameter logic [7:0]  KEY_PAUSE   = 8'h13,
  parameter int          OVER_CYCLES = 120
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [8*NUM_KEYS-1:0]   keycodes,
  input  logic                    game_over,
  output logic                    menu_active,
  output logic [NUM_GAMES-1:0]    game_sel,
  output logic                    paused,
  output logic                    over,
  output logic                    game_start
);

  // state   | meaning
  // START   | menu shown, waiting for a game key
  // PLAY    | selected game running
  // PAUSE   | selected game frozen
  // OVER    | game-over screen, timed return to START
  localparam logic [1:0] START = 2'd0;
  localparam logic [1:0] PLAY  = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] OVER  = 2'd3;

  localparam int SEL_W  = (NUM_GAMES > 1) ? $clog2(NUM_GAMES) : 1;
  localparam int CNT_W  = (OVER_CYCLES > 1) ? $clog2(OVER_CYCLES) : 1;
  localparam int NW     = NUM_GAMES + 2;
  localparam int IX_EXIT  = NUM_GAMES;
  localparam int IX_PAUSE = NUM_GAMES + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVER_CYCLES - 1);

  logic [1:0]       state, state_nxt;
  logic [SEL_W-1:0] sel, sel_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             start_nxt;
  logic [NW-1:0]    held, prev_held, press;
  logic             game_hit;
  logic [SEL_W-1:0] game_idx;

  function automatic logic [7:0] watch_code(input int j);
    if (j < NUM_GAMES)  return KEY_BASE + 8'(j);
    else if (j == IX_EXIT) return KEY_EXIT;
    else                return KEY_PAUSE;
  endfunction

  always_comb begin
    held = '0;
    for (int j = 0; j < NW; j++)
      for (int k = 0; k < NUM_KEYS; k++)
        if (keycodes[8*k +: 8] == watch_code(j)) held[j] = 1'b1;
  end

  assign press = held & ~prev_held;

  // Descending scan so the lowest pressed game index is the one kept.
  always_comb begin
    game_hit = 1'b0;
    game_idx = '0;
    for (int i = NUM_GAMES - 1; i >= 0; i--)
      if (press[i]) begin
        game_hit = 1'b1;
        game_idx = SEL_W'(i);
      end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    cnt_nxt   = '0;
    start_nxt = 1'b0;
    case (state)
      START: begin
        if (game_hit) begin
          state_nxt = PLAY;
          sel_nxt   = game_idx;
          start_nxt = 1'b1;
        end
      end
      PLAY: begin
        if (press[IX_EXIT])       state_nxt = START;
        else if (game_over)       state_nxt = OVER;
        else if (press[IX_PAUSE]) state_nxt = PAUSE;
      end
      PAUSE: begin
        if (press[IX_EXIT])       state_nxt = START;
        else if (press[IX_PAUSE]) state_nxt = PLAY;
      end
      OVER: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (press[IX_EXIT] || cnt == CNT_LAST) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = START;
    endcase
  end

  // prev_held resets to all ones so keys held through reset must be re-pressed.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= START;
      sel        <= '0;
      cnt        <= '0;
      game_start <= 1'b0;
      prev_held  <= '1;
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      cnt        <= cnt_nxt;
      game_start <= start_nxt;
      prev_held  <= held;
    end
  end

  assign menu_active = (state == START);
  assign paused      = (state == PAUSE);
  assign over        = (state == OVER);
  assign game_sel    = (state == START) ? '0 : (NUM_GAMES'(1) << sel);

endmodule

// File: tb/tb_game_mode_fsm.sv
// Bench for game_mode_fsm: directed scenarios then random key traffic,
// compared every cycle against a set-based behavioural model.
module tb_game_mode_fsm;

  localparam int         NG   = 2;
  localparam int         NK   = 2;
  localparam int         OC   = 4;
  localparam logic [7:0] KB   = 8'h1E;
  localparam logic [7:0] KX   = 8'h29;
  localparam logic [7:0] KP   = 8'h13;

  logic            Clk = 1'b0;
  logic            Reset;
  logic [8*NK-1:0] keycodes;
  logic            game_over;
  logic            menu_active;
  logic [NG-1:0]   game_sel;
  logic            paused;
  logic            over;
  logic            game_start;

  int checks   = 0;
  int failures = 0;

  // model: 0 menu, 1 play, 2 pause, 3 over
  int              m_mode, m_game, m_left;
  bit              m_pulse, m_prev_all;
  logic [8*NK-1:0] m_prev_kc;

  game_mode_fsm #(
    .NUM_GAMES(NG), .NUM_KEYS(NK), .KEY_BASE(KB), .KEY_EXIT(KX),
    .KEY_PAUSE(KP), .OVER_CYCLES(OC)
  ) dut (
    .Clk(Clk), .Reset(Reset), .keycodes(keycodes), .game_over(game_over),
    .menu_active(menu_active), .game_sel(game_sel), .paused(paused),
    .over(over), .game_start(game_start)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit in_slots(input logic [8*NK-1:0] v, input logic [7:0] c);
    for (int k = 0; k < NK; k++) if (v[8*k +: 8] == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit pressed(input logic [7:0] c);
    return in_slots(keycodes, c) && !m_prev_all && !in_slots(m_prev_kc, c);
  endfunction

  task automatic model_step();
    int  p_game;
    bit  p_exit, p_pause;
    if (Reset) begin
      m_mode = 0; m_game = 0; m_left = 0; m_pulse = 0; m_prev_all = 1;
    end else begin
      p_game = -1;
      for (int i = NG - 1; i >= 0; i--) if (pressed(8'(KB + i))) p_game = i;
      p_exit  = pressed(KX);
      p_pause = pressed(KP);
      m_pulse = 0;
      case (m_mode)
        0: if (p_game >= 0) begin m_mode = 1; m_game = p_game; m_pulse = 1; end
        1: if (p_exit) m_mode = 0;
           else if (game_over) begin m_mode = 3; m_left = OC; end
           else if (p_pause) m_mode = 2;
        2: if (p_exit) m_mode = 0; else if (p_pause) m_mode = 1;
        default: begin
          m_left--;
          if (p_exit || m_left == 0) m_mode = 0;
        end
      endcase
      m_prev_kc  = keycodes;
      m_prev_all = 0;
    end
  endtask

  task automatic cycle();
    @(posedge Clk);
    model_step();
    #1;
    check("menu_active", 32'(menu_active), 32'(m_mode == 0));
    check("game_sel", 32'(game_sel), (m_mode == 0) ? 32'd0 : (32'd1 << m_game));
    check("paused", 32'(paused), 32'(m_mode == 2));
    check("over", 32'(over), 32'(m_mode == 3));
    check("game_start", 32'(game_start), 32'(m_pulse));
  endtask

  task automatic drive(input logic [7:0] s1, input logic [7:0] s0, input bit g, input int n);
    keycodes  = {s1, s0};
    game_over = g;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    Reset = 1'b1; keycodes = '0; game_over = 1'b0;
    m_mode = 0; m_game = 0; m_left = 0; m_pulse = 0; m_prev_all = 1; m_prev_kc = '0;
    drive(8'h00, 8'h00, 0, 2);
    check("rst_menu", 32'(menu_active), 32'd1);
    check("rst_sel", 32'(game_sel), 32'd0);
    Reset = 1'b0;

    // 1: held game key acts once
    drive(8'h00, 8'h00, 0, 1);
    drive(8'h00, 8'h1E, 0, 1);
    check("t1_start", 32'(game_start), 32'd1);
    check("t1_sel", 32'(game_sel), 32'd1);
    drive(8'h00, 8'h1E, 0, 9);
    check("t1_nostart", 32'(game_start), 32'd0);
    drive(8'h00, 8'h00, 0, 1);
    drive(8'h00, 8'h29, 0, 1);
    check("t1_exit", 32'(menu_active), 32'd1);
    drive(8'h00, 8'h00, 0, 1);

    // 2: slot1 select, then simultaneous presses
    drive(8'h1F, 8'h00, 0, 1);
    check("t2_sel1", 32'(game_sel), 32'd2);
    drive(8'h00, 8'h29, 0, 1);
    drive(8'h00, 8'h00, 0, 1);
    drive(8'h1F, 8'h1E, 0, 1);
    check("t2_low_wins", 32'(game_sel), 32'd1);
    drive(8'h00, 8'h00, 0, 1);

    // 3: pause toggling, held pause toggles once
    drive(8'h00, 8'h13, 0, 1);
    check("t3_paused", 32'(paused), 32'd1);
    drive(8'h00, 8'h00, 0, 1);
    drive(8'h00, 8'h13, 0, 1);
    check("t3_resumed", 32'(paused), 32'd0);
    check("t3_nostart", 32'(game_start), 32'd0);
    drive(8'h00, 8'h00, 0, 1);
    drive(8'h13, 8'h00, 0, 5);
    check("t3_held_once", 32'(paused), 32'd1);
    drive(8'h00, 8'h00, 0, 1);
    drive(8'h00, 8'h13, 0, 1);
    drive(8'h00, 8'h00, 0, 1);

    // 4: timed game over, then early exit from OVER
    drive(8'h00, 8'h00, 1, 1);
    check("t4_over", 32'(over), 32'd1);
    drive(8'h00, 8'h00, 0, 3);
    check("t4_over_last", 32'(over), 32'd1);
    drive(8'h00, 8'h00, 0, 1);
    check("t4_back_menu", 32'(menu_active), 32'd1);
    check("t4_sel0", 32'(game_sel), 32'd0);
    drive(8'h00, 8'h1E, 0, 1);
    drive(8'h00, 8'h00, 1, 1);
    drive(8'h00, 8'h29, 0, 1);
    check("t4_exit_over", 32'(menu_active), 32'd1);
    drive(8'h00, 8'h00, 0, 1);

    // 5: simultaneous events
    drive(8'h00, 8'h1E, 0, 1);
    drive(8'h00, 8'h29, 1, 1);
    check("t5_exit_beats_over", 32'(menu_active), 32'd1);
    drive(8'h00, 8'h00, 0, 1);
    drive(8'h00, 8'h1F, 0, 1);
    drive(8'h00, 8'h13, 1, 1);
    check("t5_over_beats_pause", 32'(over), 32'd1);
    drive(8'h00, 8'h00, 0, 4);
    drive(8'h00, 8'h1E, 0, 1);
    drive(8'h00, 8'h13, 0, 1);
    drive(8'h00, 8'h00, 1, 20);
    check("t5_pause_holds", 32'(paused), 32'd1);
    drive(8'h00, 8'h29, 0, 1);
    drive(8'h00, 8'h00, 0, 1);

    // 6: key held through reset must be re-pressed
    drive(8'h00, 8'h1E, 0, 1);
    Reset = 1'b1;
    drive(8'h00, 8'h1E, 0, 1);
    Reset = 1'b0;
    drive(8'h00, 8'h1E, 0, 3);
    check("t6_still_menu", 32'(menu_active), 32'd1);
    drive(8'h00, 8'h00, 0, 1);
    drive(8'h00, 8'h1E, 0, 1);
    check("t6_repress", 32'(game_sel), 32'd1);
    check("t6_pulse", 32'(game_start), 32'd1);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] pool [6];
      logic [8*NK-1:0] kc;
      pool[0] = 8'h00; pool[1] = KB; pool[2] = 8'(KB + 1);
      pool[3] = KX; pool[4] = KP; pool[5] = 8'($urandom_range(0, 255));
      kc = keycodes;
      for (int k = 0; k < NK; k++)
        if ($urandom_range(0, 9) < 3) kc[8*k +: 8] = pool[$urandom_range(0, 5)];
      Reset = ($urandom_range(0, 299) == 0);
      drive(kc[15:8], kc[7:0], $urandom_range(0, 9) == 0, 1);
    end
    Reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_mode_fsm.md
Name: game_mode_fsm

Overview:
- Keyboard-driven top-level mode controller. Generalises the two-game start/game selector to NUM_GAMES games and NUM_KEYS simultaneous USB keycode slots.
- Adds press-edge detection, a pause state, and a game-over state with a timed return to the menu.
- Sits between the USB keycode interface and the per-game logic and color mapper. Its outputs gate which game runs and which screen is drawn.

Parameters:
- NUM_GAMES, 2, number of selectable games (1..8). Game i is selected by keycode KEY_BASE+i.
- NUM_KEYS, 2, number of 8-bit keycode slots checked each cycle (1..6).
- KEY_BASE, 8'h1E, keycode for game 0 (USB '1'). Games use consecutive codes.
- KEY_EXIT, 8'h29, keycode that returns to the menu (Esc).
- KEY_PAUSE, 8'h13, keycode that toggles pause ('p').
- OVER_CYCLES, 120, cycles spent in OVER before the automatic return to START (>=1).

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- keycodes  in  8*NUM_KEYS  packed keycode slots; slot k = keycodes[8k+7:8k]; 8'h00 = no key
- game_over  in  1  level from the active game's logic, requests end of game
- menu_active  out  1  high in START
- game_sel  out  NUM_GAMES  one-hot selected game; nonzero only in PLAY, PAUSE, OVER
- paused  out  1  high in PAUSE
- over  out  1  high in OVER
- game_start  out  1  one-cycle pulse on the first PLAY cycle entered from START (game logic resets its state on this)

Behaviour:
- One clock, Clk. Reset is synchronous and active-high. All state updates on posedge Clk.
- States: START, PLAY, PAUSE, OVER. Register sel holds the game index, width max(1, $clog2(NUM_GAMES)).
- Outputs are decoded from registered state and sel only (Moore). game_start is a registered flag.
- Key-held vector: held[j] = 1 if any slot equals watched code j. Watched codes are the NUM_GAMES game codes, KEY_EXIT and KEY_PAUSE.
- prev_held is registered every cycle. press[j] = held[j] & ~prev_held[j]. Only press, never level, causes transitions.
- Reset values: state=START, sel=0, over counter=0, game_start=0, prev_held=all ones. A key held through reset must be released and re-pressed before it acts.
- Resulting output values during reset and the first cycle after it: menu_active=1, game_sel=0, paused=0, over=0, game_start=0.
- START:
  - First game key press -> PLAY, sel=i, game_start=1 for the next cycle.
  - Several game keys pressed in the same cycle: lowest index wins.
  - KEY_EXIT, KEY_PAUSE and game_over are ignored.
- PLAY, priority highest first:
  - KEY_EXIT press -> START.
  - Else game_over=1 -> OVER, counter cleared.
  - Else KEY_PAUSE press -> PAUSE.
  - Game key presses are ignored (no mid-game switching).
- PAUSE:
  - KEY_EXIT press -> START.
  - Else KEY_PAUSE press -> PLAY. game_start is not pulsed.
  - game_over is ignored.
- OVER:
  - Counter increments each cycle.
  - KEY_EXIT press -> START immediately.
  - Else, when counter == OVER_CYCLES-1 -> START. OVER therefore lasts exactly OVER_CYCLES cycles.
- sel is unchanged on return to START. game_sel is forced to 0 in START.
- Transition latency: a press or game_over sampled at edge t changes the outputs after edge t (visible in cycle t+1).
- Illegal state encoding -> START.
- Reset asserted in any state -> START on that edge, with the reset values above. It overrides all simultaneous events.

Test Plan:
1. Reset, then slot0=8'h1E held for 10 cycles -> next cycle menu_active=0, game_sel=2'b01, game_start=1 for exactly 1 cycle; held key causes no further action.
2. From START, slot1=8'h1F pressed while slot0=8'h00 -> game_sel=2'b10. Press 8'h1E and 8'h1F in the same cycle after returning to START -> game_sel=2'b01.
3. In PLAY, press 8'h13, release, press again -> paused=1 then 0, game_sel held constant, game_start stays 0. Holding 8'h13 for 5 cycles toggles only once.
4. OVER_CYCLES=4: in PLAY, pulse game_over=1 -> over=1 for exactly 4 cycles, then menu_active=1, game_sel=0. Repeat and press 8'h29 in the 2nd OVER cycle -> START on the next cycle.
5. Simultaneous in PLAY: press 8'h29 with game_over=1 -> START, not OVER. Press 8'h13 with game_over=1 -> OVER. In PAUSE, game_over=1 for 20 cycles -> stays PAUSE.
6. Hold 8'h1E and assert Reset in PLAY, deassert with key still held -> remains START; release then re-press -> PLAY, game_sel=2'b01, game_start pulse.
